rob_retire: RTL and testbench

- Reorder buffer that turns out-of-order CDB completions into in-order retirement.
- Dispatch side: up to WAYS renamed instructions enter per cycle.
- Retire side: drives the rename table's architectural-commit interface (RRAT_ARF_idx / RRAT_idx_valid / RRAT_PRF_idx) plus except.
- Producer end of that interface; the rename block consumes it.

---
 rtl/rob_retire_pkg.sv | 24 ++
 rtl/rob_retire_select.sv | 27 ++
 rtl/rob_retire.sv | 106 ++++++++++
 tb/tb_rob_retire.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg: shared sizes, entry type and popcount helper for the reorder buffer
package rob_retire_pkg;
  localparam int WAYS = 4;
  localparam int PRF = 64;
  localparam int ROB_SIZE = 32;
  localparam int PRF_IDX_W = $clog2(PRF);
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = ROB_IDX_W + 1;
  typedef logic [PRF_IDX_W-1:0] prf_idx_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic valid;
    logic complete;
    logic mispredict;
    logic has_dest;
    logic [4:0] arf;
    prf_idx_t prf;
  } rob_entry_t;
  function automatic cnt_t ones(input logic [WAYS-1:0] v);
    ones = '0;
    for (int i = 0; i < WAYS; i++) ones += cnt_t'(v[i]);
  endfunction
endpackage

// File: rtl/rob_retire_select.sv
// rob_retire_select: in-order retire/except priority chain over the WAYS oldest entries
// Ports: heads (entries head..head+WAYS-1, oldest in slot 0), count (occupancy),
//        retire (slot retires), commit (retire & has_dest), except (mispredict retires)
module rob_retire_select
  import rob_retire_pkg::*;
(
  input  rob_entry_t [WAYS-1:0] heads,
  input  cnt_t                  count,
  output logic [WAYS-1:0]       retire,
  output logic [WAYS-1:0]       commit,
  output logic                  except
);
  logic go;
  // A mispredicted entry retires itself but blocks every younger slot.
  always_comb begin
    retire = '0;
    commit = '0;
    except = 1'b0;
    go = 1'b1;
    for (int k = 0; k < WAYS; k++) begin
      retire[k] = go & heads[k].valid & heads[k].complete & (cnt_t'(k) < count);
      commit[k] = retire[k] & heads[k].has_dest;
      except |= retire[k] & heads[k].mispredict;
      go = retire[k] & ~heads[k].mispredict;
    end
  end
endmodule

// File: rtl/rob_retire.sv
// rob_retire: reorder buffer turning out-of-order CDB completions into in-order retirement
// Ports: dispatch_* (up to WAYS renamed instructions per cycle, tag dispatch_rob_idx),
//        cdb_* (completion strobes), RRAT_* / retire_valid / except (architectural commit),
//        rob_empty. Define ROB_PERF_EN to add saturating perf_retired / perf_flushes counters.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [WAYS-1:0]                dispatch_valid,
  input  logic [WAYS-1:0][4:0]           dispatch_arf,
  input  logic [WAYS-1:0][PRF_IDX_W-1:0] dispatch_prf,
  input  logic [WAYS-1:0]                dispatch_has_dest,
  output logic [WAYS-1:0]                dispatch_ready,
  output logic [WAYS-1:0][ROB_IDX_W-1:0] dispatch_rob_idx,
  input  logic [WAYS-1:0]                cdb_valid,
  input  logic [WAYS-1:0][ROB_IDX_W-1:0] cdb_rob_idx,
  input  logic [WAYS-1:0]                cdb_mispredict,
  output logic [WAYS-1:0][4:0]           RRAT_ARF_idx,
  output logic [WAYS-1:0][PRF_IDX_W-1:0] RRAT_PRF_idx,
  output logic [WAYS-1:0]                RRAT_idx_valid,
  output logic [WAYS-1:0]                retire_valid,
  output logic                           except,
`ifdef ROB_PERF_EN
  output logic [31:0]                    perf_retired,
  output logic [15:0]                    perf_flushes,
`endif
  output logic                           rob_empty
);
  rob_entry_t rob [ROB_SIZE];
  rob_entry_t rob_n [ROB_SIZE];
  rob_entry_t [WAYS-1:0] heads;
  rob_idx_t head, tail;
  cnt_t count, n_acc, n_ret;
  logic [WAYS-1:0] accept, thermo_chk;
  // Readiness depends on the registered count only, so slots freed this cycle wait a cycle.
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      heads[k] = rob[head + rob_idx_t'(k)];
      RRAT_ARF_idx[k] = heads[k].arf;
      RRAT_PRF_idx[k] = heads[k].prf;
      dispatch_ready[k] = (cnt_t'(ROB_SIZE) - count) > cnt_t'(k);
      dispatch_rob_idx[k] = tail + rob_idx_t'(k);
    end
  end
  rob_retire_select u_sel (
    .heads  (heads),
    .count  (count),
    .retire (retire_valid),
    .commit (RRAT_idx_valid),
    .except (except)
  );
  assign accept = dispatch_valid & dispatch_ready;
  assign n_acc = ones(accept);
  assign n_ret = ones(retire_valid);
  assign rob_empty = count == '0;
  assign thermo_chk = dispatch_valid & (dispatch_valid + WAYS'(1));
  assert property (@(posedge clock) disable iff (!reset_n) thermo_chk == '0);
  // Flush wins over everything; otherwise retire clears, then CDB marks, then dispatch writes.
  // Dispatch targets only free entries, so it never collides with retire or a valid CDB hit.
  always_comb begin
    rob_n = rob;
    if (except) begin
      for (int e = 0; e < ROB_SIZE; e++) rob_n[e] = '0;
    end else begin
      for (int k = 0; k < WAYS; k++)
        if (retire_valid[k]) rob_n[head + rob_idx_t'(k)].valid = 1'b0;
      for (int i = 0; i < WAYS; i++)
        if (cdb_valid[i] && rob[cdb_rob_idx[i]].valid) begin
          rob_n[cdb_rob_idx[i]].complete = 1'b1;
          rob_n[cdb_rob_idx[i]].mispredict = rob_n[cdb_rob_idx[i]].mispredict | cdb_mispredict[i];
        end
      for (int i = 0; i < WAYS; i++)
        if (accept[i])
          rob_n[tail + rob_idx_t'(i)] = '{valid: 1'b1, complete: 1'b0, mispredict: 1'b0,
                                          has_dest: dispatch_has_dest[i], arf: dispatch_arf[i],
                                          prf: dispatch_prf[i]};
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int e = 0; e < ROB_SIZE; e++) rob[e] <= '0;
    end else begin
      head <= except ? '0 : head + rob_idx_t'(n_ret);
      tail <= except ? '0 : tail + rob_idx_t'(n_acc);
      count <= except ? '0 : count + n_acc - n_ret;
      rob <= rob_n;
    end
  end
`ifdef ROB_PERF_EN
  logic [32:0] ret_sum;
  assign ret_sum = {1'b0, perf_retired} + 33'(n_ret);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (except && perf_flushes != '1) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed stimulus with an in-order retire scoreboard for rob_retire
module tb_rob_retire;
  import rob_retire_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [WAYS-1:0] dispatch_valid, dispatch_has_dest, dispatch_ready;
  logic [WAYS-1:0][4:0] dispatch_arf;
  logic [WAYS-1:0][PRF_IDX_W-1:0] dispatch_prf;
  logic [WAYS-1:0][ROB_IDX_W-1:0] dispatch_rob_idx, cdb_rob_idx;
  logic [WAYS-1:0] cdb_valid, cdb_mispredict, RRAT_idx_valid, retire_valid;
  logic [WAYS-1:0][4:0] RRAT_ARF_idx;
  logic [WAYS-1:0][PRF_IDX_W-1:0] RRAT_PRF_idx;
  logic except, rob_empty;
`ifdef ROB_PERF_EN
  logic [31:0] perf_retired;
  logic [15:0] perf_flushes;
`endif
  rob_retire dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .dispatch_valid   (dispatch_valid),
    .dispatch_arf     (dispatch_arf),
    .dispatch_prf     (dispatch_prf),
    .dispatch_has_dest(dispatch_has_dest),
    .dispatch_ready   (dispatch_ready),
    .dispatch_rob_idx (dispatch_rob_idx),
    .cdb_valid        (cdb_valid),
    .cdb_rob_idx      (cdb_rob_idx),
    .cdb_mispredict   (cdb_mispredict),
    .RRAT_ARF_idx     (RRAT_ARF_idx),
    .RRAT_PRF_idx     (RRAT_PRF_idx),
    .RRAT_idx_valid   (RRAT_idx_valid),
    .retire_valid     (retire_valid),
    .except           (except),
`ifdef ROB_PERF_EN
    .perf_retired     (perf_retired),
    .perf_flushes     (perf_flushes),
`endif
    .rob_empty        (rob_empty)
  );
  always #5 clock = ~clock;
  int tests = 0;
  int failed = 0;
  typedef struct {
    logic [4:0] arf;
    logic [PRF_IDX_W-1:0] prf;
    logic dest;
    logic misp;
  } exp_t;
  exp_t sb[$];
  exp_t it;
  logic mon_ex;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // Monitor: every retiring slot must match the oldest expected commit.
  always @(negedge clock) begin
    if (reset_n && retire_valid != '0) begin
      mon_ex = 1'b0;
      for (int k = 0; k < WAYS; k++) begin
        if (retire_valid[k]) begin
          if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
          else begin
            it = sb.pop_front();
            check("rrat_valid", 32'(RRAT_idx_valid[k]), 32'(it.dest));
            if (it.dest) begin
              check("rrat_arf", 32'(RRAT_ARF_idx[k]), 32'(it.arf));
              check("rrat_prf", 32'(RRAT_PRF_idx[k]), 32'(it.prf));
            end
            mon_ex |= it.misp;
          end
        end
      end
      check("except", 32'(except), 32'(mon_ex));
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    dispatch_valid = '0;
    cdb_valid = '0;
    cdb_mispredict = '0;
  endtask
  task automatic disp(input int n, input int arf0, input int prf0, input logic [WAYS-1:0] hd);
    dispatch_valid = WAYS'((1 << n) - 1);
    for (int i = 0; i < WAYS; i++) begin
      dispatch_arf[i] = 5'(arf0 + i);
      dispatch_prf[i] = PRF_IDX_W'(prf0 + i);
    end
    dispatch_has_dest = hd;
  endtask
  task automatic comp(input int n, input int base, input logic [WAYS-1:0] mp);
    cdb_valid = WAYS'((1 << n) - 1);
    for (int i = 0; i < WAYS; i++) cdb_rob_idx[i] = ROB_IDX_W'(base + i);
    cdb_mispredict = mp;
  endtask
  task automatic push(input int arf, input int prf, input logic dest, input logic misp);
    exp_t e;
    e.arf = 5'(arf);
    e.prf = PRF_IDX_W'(prf);
    e.dest = dest;
    e.misp = misp;
    sb.push_back(e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    dispatch_arf = '0;
    dispatch_prf = '0;
    dispatch_has_dest = '0;
    cdb_rob_idx = '0;
    #2;
    check("rst_empty", 32'(rob_empty), 32'd1);
    check("rst_retire", 32'(retire_valid), 32'd0);
    check("rst_except", 32'(except), 32'd0);
    check("rst_ready", 32'(dispatch_ready), 32'hf);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("tags_0to3", 32'(dispatch_rob_idx), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    disp(4, 1, 40, '1);
    tick();
    idle();
    check("tail_4", 32'(dispatch_rob_idx[0]), 32'd4);
    check("not_empty", 32'(rob_empty), 32'd0);
    check("no_retire", 32'(retire_valid), 32'd0);
    check("ready_cnt4", 32'(dispatch_ready), 32'hf);
    cdb_valid = 4'b0011;
    cdb_rob_idx[0] = 5'd2;
    cdb_rob_idx[1] = 5'd0;
    push(1, 40, 1'b1, 1'b0);
    tick();
    check("ooo_slot0", 32'(retire_valid), 32'h1);
    cdb_valid = 4'b0011;
    cdb_rob_idx[0] = 5'd1;
    cdb_rob_idx[1] = 5'd3;
    push(2, 41, 1'b1, 1'b0);
    push(3, 42, 1'b1, 1'b0);
    push(4, 43, 1'b1, 1'b0);
    tick();
    idle();
    check("ooo_slots012", 32'(retire_valid), 32'h7);
    tick();
    check("drained_1", 32'(rob_empty), 32'd1);
    disp(4, 5, 44, 4'b1101);
    tick();
    idle();
    comp(4, 4, '0);
    push(5, 44, 1'b1, 1'b0);
    push(6, 45, 1'b0, 1'b0);
    push(7, 46, 1'b1, 1'b0);
    push(8, 47, 1'b1, 1'b0);
    tick();
    idle();
    check("nodest_retire", 32'(retire_valid), 32'hf);
    check("nodest_rrat", 32'(RRAT_idx_valid), 32'hd);
    tick();
    check("drained_2", 32'(rob_empty), 32'd1);
    disp(4, 9, 48, '1);
    tick();
    idle();
    comp(4, 8, 4'b0010);
    push(9, 48, 1'b1, 1'b0);
    push(10, 49, 1'b1, 1'b1);
    tick();
    idle();
    check("misp_retire", 32'(retire_valid), 32'h3);
    check("misp_except", 32'(except), 32'd1);
    disp(2, 20, 60, '1);
    tick();
    idle();
    check("flush_empty", 32'(rob_empty), 32'd1);
    check("flush_except_low", 32'(except), 32'd0);
    check("flush_tail0", 32'(dispatch_rob_idx[0]), 32'd0);
    check("flush_no_retire", 32'(retire_valid), 32'd0);
    tick();
    check("flush_still_empty", 32'(rob_empty), 32'd1);
    for (int c = 0; c < 8; c++) begin
      check("fill_ready", 32'(dispatch_ready), 32'hf);
      disp(4, 4 * c, 4 * c, '1);
      tick();
    end
    idle();
    check("full_ready", 32'(dispatch_ready), 32'h0);
    disp(4, 1, 1, '1);
    tick();
    idle();
    check("full_tail", 32'(dispatch_rob_idx[0]), 32'd0);
    comp(2, 0, '0);
    push(0, 0, 1'b1, 1'b0);
    push(1, 1, 1'b1, 1'b0);
    tick();
    idle();
    check("ready_registered", 32'(dispatch_ready), 32'h0);
    tick();
    check("ready_two", 32'(dispatch_ready), 32'h3);
    disp(2, 30, 62, '1);
    tick();
    idle();
    check("refull_ready", 32'(dispatch_ready), 32'h0);
    for (int b = 0; b < 7; b++) begin
      comp(4, 2 + 4 * b, '0);
      for (int i = 0; i < 4; i++) push(2 + 4 * b + i, 2 + 4 * b + i, 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    check("head30_wait", 32'(retire_valid), 32'd0);
    check("head30_tail", 32'(dispatch_rob_idx[0]), 32'd2);
    comp(4, 30, '0);
    push(30, 30, 1'b1, 1'b0);
    push(31, 31, 1'b1, 1'b0);
    push(30, 62, 1'b1, 1'b0);
    push(31, 63, 1'b1, 1'b0);
    tick();
    idle();
    check("wrap_retire", 32'(retire_valid), 32'hf);
    check("wrap_prf", 32'(RRAT_PRF_idx), 32'({6'd63, 6'd62, 6'd31, 6'd30}));
    tick();
    check("drained_3", 32'(rob_empty), 32'd1);
`ifdef ROB_PERF_EN
    check("perf_retired", perf_retired, 32'd44);
    check("perf_flushes", 32'(perf_flushes), 32'd1);
`endif
    disp(4, 1, 1, '1);
    tick();
    disp(4, 5, 5, '1);
    tick();
    disp(2, 9, 9, '1);
    tick();
    idle();
    comp(1, 2, '0);
    tick();
    idle();
    check("pre_reset_ret", 32'(retire_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_retire", 32'(retire_valid), 32'd0);
    check("async_rrat", 32'(RRAT_idx_valid), 32'd0);
    check("async_empty", 32'(rob_empty), 32'd1);
    check("async_ready", 32'(dispatch_ready), 32'hf);
`ifdef ROB_PERF_EN
    check("perf_rst_retired", perf_retired, 32'd0);
    check("perf_rst_flushes", 32'(perf_flushes), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("post_rst_tail", 32'(dispatch_rob_idx[0]), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
